mem_stage: RTL

Memory-access stage of the five-stage pipelined processor. It sits directly downstream of the EX/MEM pipeline register. It consumes the registered MEM-side control and data, performs load/store through a ready/acknowledge data-memory port with wait states, resolves the branch decision, and registers results into the MEM/WB boundary. It raises a stall while a memory access is outstanding and flags misaligned or timed-out accesses.

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/memwb_reg.sv | 28 ++
 rtl/mem_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared types and widths for the pipeline MEM stage
package pipeline_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic                  memtoreg;
        logic                  regwrite;
        logic [WORD_W-1:0]     rdata;
        logic [WORD_W-1:0]     alures;
        logic [REG_ADDR_W-1:0] wreg;
    } memwb_t;

endpackage

// File: rtl/memwb_reg.sv
// rtl/memwb_reg.sv - MEM/WB pipeline register with enable and bubble insert
module memwb_reg
    import pipeline_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   en_i,
    input  memwb_t d_i,
    output memwb_t q_o
);

    memwb_t q_q;

    // Capture when the stage advances; otherwise kill the controls so WB sees a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end else begin
            q_q.regwrite <= 1'b0;
            q_q.memtoreg <= 1'b0;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: data-memory access FSM, branch resolve, MEM/WB register
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MEMMemRead,
    input  logic                  MEMMemWrite,
    input  logic                  MEMBranch,
    input  logic                  MEMMemtoReg,
    input  logic                  MEMRegWrite,
    input  logic                  MEMzero,
    input  logic [WORD_W-1:0]     MEMEA,
    input  logic [WORD_W-1:0]     MEMALURes,
    input  logic [WORD_W-1:0]     MEMreadData2,
    input  logic [REG_ADDR_W-1:0] MEMwriteReg,
    output logic                  dmemReq,
    output logic                  dmemWe,
    output logic [WORD_W-1:0]     dmemAddr,
    output logic [WORD_W-1:0]     dmemWData,
    input  logic [WORD_W-1:0]     dmemRData,
    input  logic                  dmemAck,
    output logic                  stall,
    output logic                  PCSrc,
    output logic [WORD_W-1:0]     branchTarget,
    output logic                  WBMemtoReg,
    output logic                  WBRegWrite,
    output logic [WORD_W-1:0]     WBreadData,
    output logic [WORD_W-1:0]     WBALURes,
    output logic [REG_ADDR_W-1:0] WBwriteReg,
    output logic                  misalignErr,
    output logic                  busErr
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    mem_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic misalign_err_q, bus_err_q;

    logic mem_op, aligned, is_load, misalign;
    logic req_c, stall_c, timeout_c;
    memwb_t wb_d, wb_q;

    assign mem_op   = MEMMemRead | MEMMemWrite;
    assign aligned  = (MEMALURes[1:0] == 2'b00);
    // A simultaneous read+write behaves as a store, so it never returns load data.
    assign is_load  = MEMMemRead & ~MEMMemWrite;
    assign misalign = (state_q == IDLE) & mem_op & ~aligned;

    // Next-state, request and stall decode for the access handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        timeout_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && aligned) begin
                    req_c = 1'b1;
                    if (!dmemAck) begin
                        stall_c = 1'b1;
                        state_d = WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                req_c = 1'b1;
                if (dmemAck) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout_c = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state, wait counter and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            misalign_err_q <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (misalign) begin
                misalign_err_q <= 1'b1;
            end
            if (timeout_c) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    // Payload offered to the MEM/WB register on every advancing edge.
    always_comb begin
        wb_d          = '0;
        wb_d.memtoreg = MEMMemtoReg;
        wb_d.regwrite = MEMRegWrite & ~misalign & ~timeout_c;
        wb_d.rdata    = (req_c && dmemAck && is_load) ? dmemRData : '0;
        wb_d.alures   = MEMALURes;
        wb_d.wreg     = MEMwriteReg;
    end

    memwb_reg u_memwb (
        .clk_i (clk),
        .rst_i (reset),
        .en_i  (~stall_c),
        .d_i   (wb_d),
        .q_o   (wb_q)
    );

    // Request and stall are gated by reset so a pending access is dropped at once.
    assign dmemReq      = req_c & ~reset;
    assign stall        = stall_c & ~reset;
    assign dmemWe       = MEMMemWrite;
    assign dmemAddr     = MEMALURes;
    assign dmemWData    = MEMreadData2;

    assign PCSrc        = MEMBranch & MEMzero;
    assign branchTarget = MEMEA;

    assign WBMemtoReg   = wb_q.memtoreg;
    assign WBRegWrite   = wb_q.regwrite;
    assign WBreadData   = wb_q.rdata;
    assign WBALURes     = wb_q.alures;
    assign WBwriteReg   = wb_q.wreg;
    assign misalignErr  = misalign_err_q;
    assign busErr       = bus_err_q;

endmodule
